// File: rtl/p_mul_pkg.sv
// Shared types and helpers for the p_mul arbiter: FSM encoding, pack-width bit
// positions and the one-hot pack-width check.
package p_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  function automatic logic pw_onehot(input logic [4:0] pw);
    return (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/p_mul_arbiter_if.sv
// Bundle of the two requester ports (request + response) and the p_mul port.
// slave = arbiter view, master = environment (requesters and p_mul) view.
interface p_mul_arbiter_if;
  logic        rq0_valid, rq0_ready, rq0_mul_l, rq0_mul_h, rq0_clmul;
  logic [4:0]  rq0_pw;
  logic [31:0] rq0_crs1, rq0_crs2;
  logic        rq1_valid, rq1_ready, rq1_mul_l, rq1_mul_h, rq1_clmul;
  logic [4:0]  rq1_pw;
  logic [31:0] rq1_crs1, rq1_crs2;

  logic        rs0_valid, rs0_ready, rs0_err;
  logic [31:0] rs0_result;
  logic        rs1_valid, rs1_ready, rs1_err;
  logic [31:0] rs1_result;

  logic        m_valid, m_ready, m_mul_l, m_mul_h, m_clmul;
  logic [4:0]  m_pw;
  logic [31:0] m_crs1, m_crs2, m_result;

  modport slave (
    input  rq0_valid, rq0_mul_l, rq0_mul_h, rq0_clmul, rq0_pw, rq0_crs1, rq0_crs2,
    input  rq1_valid, rq1_mul_l, rq1_mul_h, rq1_clmul, rq1_pw, rq1_crs1, rq1_crs2,
    output rq0_ready, rq1_ready,
    output rs0_valid, rs0_err, rs0_result, rs1_valid, rs1_err, rs1_result,
    input  rs0_ready, rs1_ready,
    output m_valid, m_mul_l, m_mul_h, m_clmul, m_pw, m_crs1, m_crs2,
    input  m_ready, m_result
  );

  modport master (
    output rq0_valid, rq0_mul_l, rq0_mul_h, rq0_clmul, rq0_pw, rq0_crs1, rq0_crs2,
    output rq1_valid, rq1_mul_l, rq1_mul_h, rq1_clmul, rq1_pw, rq1_crs1, rq1_crs2,
    input  rq0_ready, rq1_ready,
    input  rs0_valid, rs0_err, rs0_result, rs1_valid, rs1_err, rs1_result,
    output rs0_ready, rs1_ready,
    input  m_valid, m_mul_l, m_mul_h, m_clmul, m_pw, m_crs1, m_crs2,
    output m_ready, m_result
  );
endinterface

// File: rtl/p_mul_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the tie winner and moves to the
// other requester whenever a grant is issued.
module p_mul_rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       gidx
);
  logic ptr;

  always_comb begin
    gidx  = (req == 2'b11) ? ptr : req[1];
    grant = en ? (req & (gidx ? 2'b10 : 2'b01)) : 2'b00;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       ptr <= RR_INIT;
    else if (|grant) ptr <= ~gidx;
  end
endmodule

// File: rtl/p_mul_arbiter.sv
// Shares one p_mul between two requesters: accept -> issue -> respond, one
// operation in flight, round-robin on ties, malformed pack widths bypass p_mul.
module p_mul_arbiter
  import p_mul_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  p_mul_arbiter_if.slave   bus
);
  state_t      state_q, state_d;
  logic [1:0]  grant;
  logic        gidx, accept, owner_q;
  logic        sel_mul_l, sel_mul_h, sel_clmul;
  logic [4:0]  sel_pw;
  logic [31:0] sel_crs1, sel_crs2;
  logic        mul_l_q, mul_h_q, clmul_q, err_q;
  logic [4:0]  pw_q;
  logic [31:0] crs1_q, crs2_q, result_q;
  logic        rs_hs;

  p_mul_rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clock (clock),
    .reset (reset),
    .en    (state_q == IDLE),
    .req   ({bus.rq1_valid, bus.rq0_valid}),
    .grant (grant),
    .gidx  (gidx)
  );

  assign accept        = |grant;
  assign bus.rq0_ready = grant[0];
  assign bus.rq1_ready = grant[1];

  always_comb begin
    sel_mul_l = gidx ? bus.rq1_mul_l : bus.rq0_mul_l;
    sel_mul_h = gidx ? bus.rq1_mul_h : bus.rq0_mul_h;
    sel_clmul = gidx ? bus.rq1_clmul : bus.rq0_clmul;
    sel_pw    = gidx ? bus.rq1_pw    : bus.rq0_pw;
    sel_crs1  = gidx ? bus.rq1_crs1  : bus.rq0_crs1;
    sel_crs2  = gidx ? bus.rq1_crs2  : bus.rq0_crs2;
  end

  assign rs_hs = owner_q ? bus.rs1_ready : bus.rs0_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // m_valid decodes straight from the state register so the async reset drops it at once
  always_comb begin
    state_d       = state_q;
    bus.m_valid   = 1'b0;
    bus.rs0_valid = 1'b0;
    bus.rs1_valid = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = pw_onehot(sel_pw) ? ISSUE : RESP;
      ISSUE: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_d = RESP;
      end
      RESP: begin
        bus.rs0_valid = ~owner_q;
        bus.rs1_valid = owner_q;
        if (rs_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= 1'b0;
      mul_l_q  <= 1'b0;
      mul_h_q  <= 1'b0;
      clmul_q  <= 1'b0;
      pw_q     <= '0;
      crs1_q   <= '0;
      crs2_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      owner_q <= gidx;
      mul_l_q <= sel_mul_l;
      mul_h_q <= sel_mul_h;
      clmul_q <= sel_clmul;
      pw_q    <= sel_pw;
      crs1_q  <= sel_crs1;
      crs2_q  <= sel_crs2;
      if (!pw_onehot(sel_pw)) begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
    end else if (state_q == ISSUE && bus.m_ready) begin
      result_q <= bus.m_result;
      err_q    <= 1'b0;
    end
  end

  assign bus.m_mul_l    = mul_l_q;
  assign bus.m_mul_h    = mul_h_q;
  assign bus.m_clmul    = clmul_q;
  assign bus.m_pw       = pw_q;
  assign bus.m_crs1     = crs1_q;
  assign bus.m_crs2     = crs2_q;
  assign bus.rs0_result = result_q;
  assign bus.rs1_result = result_q;
  assign bus.rs0_err    = err_q & bus.rs0_valid;
  assign bus.rs1_err    = err_q & bus.rs1_valid;
endmodule

// File: tb/tb_p_mul_arbiter.sv
// Directed bench for p_mul_arbiter; the bench plays both requesters and p_mul.
module tb_p_mul_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  p_mul_arbiter_if bus();

  p_mul_arbiter #(.RR_INIT(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic set_rq(input int idx, input logic v, input logic ml, input logic mh,
                        input logic cl, input logic [4:0] pw, input logic [31:0] a,
                        input logic [31:0] b);
    if (idx == 0) begin
      bus.rq0_valid = v; bus.rq0_mul_l = ml; bus.rq0_mul_h = mh; bus.rq0_clmul = cl;
      bus.rq0_pw = pw; bus.rq0_crs1 = a; bus.rq0_crs2 = b;
    end else begin
      bus.rq1_valid = v; bus.rq1_mul_l = ml; bus.rq1_mul_h = mh; bus.rq1_clmul = cl;
      bus.rq1_pw = pw; bus.rq1_crs1 = a; bus.rq1_crs2 = b;
    end
  endtask

  // Starts and ends on a falling edge; ok reports whether rq_ready was seen.
  task automatic send(input int idx, input logic ml, input logic mh, input logic cl,
                      input logic [4:0] pw, input logic [31:0] a, input logic [31:0] b,
                      output bit ok);
    ok = 1'b0;
    set_rq(idx, 1'b1, ml, mh, cl, pw, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((idx == 0) ? bus.rq0_ready : bus.rq1_ready) ok = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    set_rq(idx, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic serve(input logic [31:0] res, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.m_valid) begin
        seen = 1'b1;
        bus.m_ready  = 1'b1;
        bus.m_result = res;
      end
      @(negedge clock);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic get_resp(input int idx, output bit seen, output logic [31:0] res,
                          output logic err, output bit other);
    seen = 1'b0; other = 1'b0; res = 'x; err = 1'bx;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if ((idx == 0) ? bus.rs1_valid : bus.rs0_valid) other = 1'b1;
      if ((idx == 0) ? bus.rs0_valid : bus.rs1_valid) begin
        seen = 1'b1;
        res  = (idx == 0) ? bus.rs0_result : bus.rs1_result;
        err  = (idx == 0) ? bus.rs0_err : bus.rs1_err;
        if (idx == 0) bus.rs0_ready = 1'b1; else bus.rs1_ready = 1'b1;
      end
      @(negedge clock);
    end
    bus.rs0_ready = 1'b0;
    bus.rs1_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0 || bus.rs0_valid !== 1'b0 || bus.rs1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: m=%b rs0=%b rs1=%b, want 0 0 0", bus.m_valid, bus.rs0_valid, bus.rs1_valid);
    end
    n_checks++;
    if (bus.rq0_ready !== 1'b0 || bus.rq1_ready !== 1'b0 || bus.m_crs1 !== 32'd0 || bus.rs0_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: rq_ready=%b%b crs1=%h result=%h, want 00 0 0", bus.rq1_ready, bus.rq0_ready, bus.m_crs1, bus.rs0_result);
    end
    @(negedge clock);
  endtask

  task automatic test_pw16_lo();
    bit ok, seen, other; logic [31:0] res; logic err;
    send(0, 1'b1, 1'b0, 1'b0, 5'b00010, 32'h0003_0002, 32'h0005_0004, ok);
    #1;
    n_checks++;
    if (!ok || bus.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pw16_issue: accepted=%b m_valid=%b, want 1 1", ok, bus.m_valid);
    end
    n_checks++;
    if (bus.m_crs1 !== 32'h0003_0002 || bus.m_crs2 !== 32'h0005_0004 || bus.m_pw !== 5'b00010 ||
        bus.m_mul_l !== 1'b1 || bus.m_mul_h !== 1'b0 || bus.m_clmul !== 1'b0) begin
      n_fail++;
      $display("FAIL pw16_operands: crs1=%h crs2=%h pw=%b l/h/c=%b%b%b, want 00030002 00050004 00010 100",
               bus.m_crs1, bus.m_crs2, bus.m_pw, bus.m_mul_l, bus.m_mul_h, bus.m_clmul);
    end
    @(negedge clock);
    serve(32'h000F_0008, seen);
    get_resp(0, seen, res, err, other);
    n_checks++;
    if (!seen || other || res !== 32'h000F_0008 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pw16_resp: seen=%b other=%b result=%h err=%b, want 1 0 000f0008 0", seen, other, res, err);
    end
  endtask

  task automatic test_pw32_hi();
    bit ok, seen, other; logic [31:0] res; logic err;
    send(1, 1'b0, 1'b1, 1'b0, 5'b00001, 32'hFFFF_FFFF, 32'h0000_0002, ok);
    #1;
    n_checks++;
    if (!ok || bus.m_valid !== 1'b1 || bus.m_mul_h !== 1'b1 || bus.m_pw !== 5'b00001 || bus.m_crs1 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL pw32_issue: ok=%b m_valid=%b mul_h=%b pw=%b crs1=%h", ok, bus.m_valid, bus.m_mul_h, bus.m_pw, bus.m_crs1);
    end
    @(negedge clock);
    serve(32'h0000_0001, seen);
    get_resp(1, seen, res, err, other);
    n_checks++;
    if (!seen || other || res !== 32'h0000_0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pw32_resp: seen=%b rs0_seen=%b result=%h err=%b, want 1 0 00000001 0", seen, other, res, err);
    end
  endtask

  task automatic test_round_robin();
    bit seen, other; logic [31:0] res; logic err;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      set_rq(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 32'd10 + i, 32'd3);
      set_rq(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 32'd20 + i, 32'd3);
      #1;
      n_checks++;
      if (bus.rq0_ready !== (g == 0) || bus.rq1_ready !== (g == 1)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: rq_ready=%b%b, want grant %0d", i, bus.rq1_ready, bus.rq0_ready, g);
      end
      @(posedge clock);
      @(negedge clock);
      set_rq(0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      set_rq(1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      serve(32'h100 + i, seen);
      get_resp(g, seen, res, err, other);
      n_checks++;
      if (!seen || other || res !== 32'h100 + i) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: seen=%b other=%b result=%h, want 1 0 %h", i, seen, other, res, 32'h100 + i);
      end
    end
  endtask

  task automatic test_bad_pw();
    bit ok; int mv = 0;
    send(0, 1'b1, 1'b0, 1'b0, 5'b00011, 32'h1234_5678, 32'h9ABC_DEF0, ok);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.m_valid) mv++;
      if (i == 0) begin
        n_checks++;
        if (!ok || bus.rs0_valid !== 1'b1 || bus.rs0_err !== 1'b1 || bus.rs0_result !== 32'd0) begin
          n_fail++;
          $display("FAIL badpw_resp: ok=%b rs0_valid=%b err=%b result=%h, want 1 1 1 0", ok, bus.rs0_valid, bus.rs0_err, bus.rs0_result);
        end
      end
      @(negedge clock);
    end
    n_checks++;
    if (mv != 0) begin
      n_fail++;
      $display("FAIL badpw_mvalid: m_valid high %0d cycles, want 0", mv);
    end
    bus.rs0_ready = 1'b1;
    @(negedge clock);
    bus.rs0_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, seen, other; logic [31:0] res; logic err;
    int bad = 0;
    send(0, 1'b0, 1'b0, 1'b1, 5'b00100, 32'h0102_0304, 32'h0506_0708, ok);
    serve(32'hCAFE_1234, seen);
    set_rq(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b01000, 32'h2222_2222, 32'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rs0_valid !== 1'b1 || bus.rs0_result !== 32'hCAFE_1234 || bus.rq1_ready !== 1'b0) bad++;
      @(negedge clock);
    end
    n_checks++;
    if (!ok || !seen || bad != 0) begin
      n_fail++;
      $display("FAIL hold_resp: ok=%b served=%b bad_cycles=%0d, want 1 1 0", ok, seen, bad);
    end
    bus.rs0_ready = 1'b1;
    @(negedge clock);
    bus.rs0_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.rq1_ready !== 1'b1 || bus.rs0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: rq1_ready=%b rs0_valid=%b, want 1 0", bus.rq1_ready, bus.rs0_valid);
    end
    @(posedge clock);
    @(negedge clock);
    set_rq(1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_pw !== 5'b01000 || bus.m_crs1 !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL b2b_issue: m_valid=%b pw=%b crs1=%h, want 1 01000 22222222", bus.m_valid, bus.m_pw, bus.m_crs1);
    end
    @(negedge clock);
    serve(32'h0BAD_F00D, seen);
    get_resp(1, seen, res, err, other);
    n_checks++;
    if (!seen || other || res !== 32'h0BAD_F00D || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp: seen=%b other=%b result=%h err=%b, want 1 0 0badf00d 0", seen, other, res, err);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit ok, seen, other; logic [31:0] res; logic err;
    int stray = 0;
    send(0, 1'b1, 1'b0, 1'b0, 5'b00001, 32'd7, 32'd6, ok);
    #1;
    n_checks++;
    if (!ok || bus.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: ok=%b m_valid=%b, want 1 1", ok, bus.m_valid);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: m_valid=%b, want 0", bus.m_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.rs0_valid || bus.rs1_valid || bus.m_valid) stray++;
      @(negedge clock);
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_discard: stray valid cycles=%0d, want 0", stray);
    end
    send(1, 1'b1, 1'b0, 1'b0, 5'b10000, 32'h0303_0303, 32'h0202_0202, ok);
    serve(32'h0606_0606, seen);
    get_resp(1, seen, res, err, other);
    n_checks++;
    if (!ok || !seen || other || res !== 32'h0606_0606 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: ok=%b seen=%b other=%b result=%h err=%b, want 1 1 0 06060606 0", ok, seen, other, res, err);
    end
  endtask

  initial begin
    set_rq(0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_rq(1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus.rs0_ready = 1'b0;
    bus.rs1_ready = 1'b0;
    bus.m_ready   = 1'b0;
    bus.m_result  = 32'd0;
    @(negedge clock);
    test_reset();
    test_pw16_lo();
    test_pw32_hi();
    test_round_robin();
    test_bad_pw();
    test_back_to_back();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
